// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned STAT_W   = 16;
  localparam int unsigned MAX_WAIT = 15;

endpackage

// File: rtl/dmem_array.sv
// Byte-lane word array: synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable wait states.
// Optional load/store counters are built when DMEM_STATS_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] wr_count
`endif
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitLast = 4'((WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] wdata_q;

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [BE_W-1:0]   cur_be;
  logic [WORD_W-1:0] cur_wdata;
  logic              cur_err;
  logic              mem_we;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] rdata_d;

  assign accept = req_valid && req_ready;

  // With zero wait states the response is formed on the accept edge, before the
  // capture registers hold the request, so the live inputs are used in IDLE.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_be    = req_be;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_be    = be_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    enter_resp = 1'b0;
    if (state_q == StIdle) begin
      enter_resp = accept && (WaitLast == 4'd0);
    end else if (state_q == StWait) begin
      enter_resp = ((cnt_q + 4'd1) == WaitLast);
    end
  end

  assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));
  assign mem_we  = reset && enter_resp && cur_we && !cur_err;
  assign rdata_d = (!cur_we && !cur_err) ? arr_rdata : '0;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IdxW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (cur_be),
    .idx   (cur_addr[IdxW+1:2]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            be_q      <= req_be;
            wdata_q   <= req_wdata;
            cnt_q     <= 4'd0;
            req_ready <= 1'b0;
            state_q   <= enter_resp ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 4'd1;
          if (enter_resp) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
      resp_valid <= enter_resp;
      if (enter_resp) begin
        resp_rdata <= rdata_d;
        resp_err   <= cur_err;
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (enter_resp && !cur_err) begin
      if (cur_we) begin
        if (wr_count != '1) wr_count <= wr_count + 1'b1;
      end else begin
        if (rd_count != '1) rd_count <= rd_count + 1'b1;
      end
    end
  end
`endif

endmodule
